// File: rtl/rgb_pixel_framer.sv
// rgb_pixel_framer
//   Packs a raster-order R,G,B byte stream into 24-bit pixels. Each pixel is
//   tagged with its column/row and with start-of-frame, end-of-line and
//   end-of-frame flags. It is then held in a single-entry output register
//   until the sink takes it.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   in_byte is valid
//   in_byte    in   processed byte (R, G, B order per pixel)
//   in_ready   out  byte accepted when in_valid && in_ready
//   out_valid  out  output register holds a pixel
//   out_ready  in   sink takes the pixel when out_valid && out_ready
//   out_rgb    out  {R, G, B}
//   out_x      out  column of held pixel
//   out_y      out  row of held pixel
//   out_sof    out  held pixel is (0,0)
//   out_eol    out  held pixel is last in its row
//   out_eof    out  held pixel is last in the frame
//   frame_cnt  out  completed frames, wraps modulo 256
module rgb_pixel_framer #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 128,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_byte,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_rgb,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic [7:0]    frame_cnt
);

    localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
    localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

    logic [1:0]    ph;
    logic [7:0]    r_byte;
    logic [7:0]    g_byte;
    logic [XW-1:0] px;
    logic [YW-1:0] py;

    logic in_acc;
    logic pix_load;

    // The B byte may only enter when the output slot is free or is emptied on
    // this same edge; R and G are parked internally and never block.
    assign in_ready = !rst && ((ph != 2'd2) || !out_valid || out_ready);
    assign in_acc   = in_valid && in_ready;
    assign pix_load = in_acc && (ph == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            ph        <= 2'd0;
            r_byte    <= 8'd0;
            g_byte    <= 8'd0;
            px        <= '0;
            py        <= '0;
            out_valid <= 1'b0;
            out_rgb   <= 24'd0;
            out_x     <= '0;
            out_y     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (in_acc) begin
                if (ph == 2'd0) r_byte <= in_byte;
                if (ph == 2'd1) g_byte <= in_byte;
                ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            end

            if (pix_load) begin
                // A load wins over a simultaneous transfer: the slot is refilled.
                out_valid <= 1'b1;
                out_rgb   <= {r_byte, g_byte, in_byte};
                out_x     <= px;
                out_y     <= py;
                out_sof   <= (px == '0) && (py == '0);
                out_eol   <= (px == XLast);
                out_eof   <= (px == XLast) && (py == YLast);

                // Coordinates track loaded pixels, not sink transfers.
                if (px == XLast) begin
                    px <= '0;
                    if (py == YLast) begin
                        py        <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        py <= py + YW'(1);
                    end
                end else begin
                    px <= px + XW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pixel_framer.sv
// Testbench for rgb_pixel_framer. Uses a small non-power-of-two geometry so
// that row/frame wrap and the 256-frame counter wrap fit in a short run.
module tb_rgb_pixel_framer;

    localparam int W   = 6;
    localparam int H   = 3;
    localparam int PPF = W * H;
    localparam int BPF = PPF * 3;
    localparam int XW  = $clog2(W);
    localparam int YW  = $clog2(H);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'd0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [23:0]   out_rgb;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic [7:0]    frame_cnt;

    int checks = 0;
    int errors = 0;

    rgb_pixel_framer #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rgb  (out_rgb),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expectations come from counting accepted bytes and loaded pixels since
    // reset: pixel n sits at (n mod W, (n div W) mod H), and the frame count is
    // the number of whole frames loaded.
    int          nb = 0;
    int          pix_loaded = 0;
    bit          m_valid = 0;
    logic [7:0]  m_r, m_g;
    logic [23:0] m_rgb = 0;
    int          m_x = 0, m_y = 0;
    bit          m_sof = 0, m_eol = 0, m_eof = 0;
    int          m_frames = 0;
    logic [23:0] sink_q[$];

    bit exp_ready, acc, xfer, ld;

    always @(negedge clk) begin
        exp_ready = !rst && ((nb % 3) != 2 || !m_valid || out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_rgb", 32'(out_rgb), 32'(m_rgb));
            check("out_x", 32'(out_x), 32'(m_x));
            check("out_y", 32'(out_y), 32'(m_y));
            check("out_sof", 32'(out_sof), 32'(m_sof));
            check("out_eol", 32'(out_eol), 32'(m_eol));
            check("out_eof", 32'(out_eof), 32'(m_eof));
        end
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));

        if (!rst && out_valid && out_ready) sink_q.push_back(out_rgb);

        if (rst) begin
            nb         = 0;
            pix_loaded = 0;
            m_valid    = 0;
            m_frames   = 0;
        end else begin
            acc  = in_valid && exp_ready;
            xfer = m_valid && out_ready;
            ld   = acc && (nb % 3) == 2;
            if (acc) begin
                case (nb % 3)
                    0: m_r = in_byte;
                    1: m_g = in_byte;
                    default: begin
                        m_rgb = {m_r, m_g, in_byte};
                        m_x   = pix_loaded % W;
                        m_y   = (pix_loaded / W) % H;
                        m_sof = (pix_loaded % PPF) == 0;
                        m_eol = m_x == W - 1;
                        m_eof = (pix_loaded % PPF) == PPF - 1;
                        pix_loaded++;
                        m_frames = (pix_loaded / PPF) % 256;
                        m_valid  = 1;
                    end
                endcase
                nb++;
            end
            if (!ld && xfer) m_valid = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    logic [7:0] src[];
    int         idx;
    int         nbytes;
    bit         racc;

    initial begin
        // Reset state and single pixel.
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_rgb", 32'(out_rgb), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_flags", 32'({out_sof, out_eol, out_eof}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        out_ready = 1'b1;
        drive_byte(8'h11);
        drive_byte(8'h22);
        drive_byte(8'h33);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_rgb", 32'(out_rgb), 32'h112233);
        check("t1_xy", 32'({out_x, out_y}), 32'd0);
        check("t1_sof", 32'(out_sof), 32'd1);
        check("t1_eol", 32'(out_eol), 32'd0);
        cyc();
        check("t1_drained", 32'(out_valid), 32'd0);

        // Full frame plus one pixel, byte value = index mod 256.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < BPF + 3; i++) begin
            drive_byte(8'(i));
            if (i % 3 == 2) begin
                if (i / 3 == W - 1) begin
                    check("t2_eol", 32'(out_eol), 32'd1);
                    check("t2_eol_x", 32'(out_x), 32'(W - 1));
                    check("t2_eol_y", 32'(out_y), 32'd0);
                    check("t2_eol_rgb", 32'(out_rgb), 32'h0F1011);
                end
                if (i / 3 == PPF - 1) begin
                    check("t2_eof", 32'(out_eof), 32'd1);
                    check("t2_eof_x", 32'(out_x), 32'(W - 1));
                    check("t2_eof_y", 32'(out_y), 32'(H - 1));
                    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
                end
                if (i / 3 == PPF) begin
                    check("t2_next_sof", 32'(out_sof), 32'd1);
                    check("t2_next_xy", 32'({out_x, out_y}), 32'd0);
                end
            end
        end
        cyc();

        // Reset with ph=1, one pixel held and frame_cnt nonzero.
        out_ready = 1'b0;
        drive_byte(8'hB0);
        drive_byte(8'hB1);
        drive_byte(8'hB2);
        drive_byte(8'hB3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_frame_cnt", 32'(frame_cnt), 32'd0);
        out_ready = 1'b1;
        drive_byte(8'h01);
        drive_byte(8'h02);
        drive_byte(8'h03);
        check("t4_rgb", 32'(out_rgb), 32'h010203);
        check("t4_xy", 32'({out_x, out_y}), 32'd0);
        check("t4_sof", 32'(out_sof), 32'd1);
        cyc();

        // Backpressure: held pixel, then R and G absorbed, B blocked.
        do_reset();
        out_ready = 1'b0;
        drive_byte(8'h51);
        drive_byte(8'h52);
        drive_byte(8'h53);
        drive_byte(8'hA0);
        drive_byte(8'hA1);
        in_valid = 1'b1;
        in_byte  = 8'hA2;
        @(negedge clk);
        check("t3_blocked", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        cyc();
        check("t3_hold_rgb", 32'(out_rgb), 32'h515253);
        check("t3_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("t3_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t3_new_rgb", 32'(out_rgb), 32'hA0A1A2);
        check("t3_new_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        cyc();

        // Random valid/ready over two frames, compared against source triples.
        do_reset();
        nbytes = 2 * BPF;
        src    = new[nbytes];
        foreach (src[i]) src[i] = 8'($urandom);
        sink_q.delete();
        idx = 0;
        for (int c = 0; c < 20000 && (idx < nbytes || sink_q.size() < nbytes / 3); c++) begin
            in_valid  = (idx < nbytes) && ($urandom % 2 == 1);
            in_byte   = (idx < nbytes) ? src[idx] : 8'd0;
            out_ready = ($urandom % 2 == 1);
            @(negedge clk);
            racc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (racc) idx++;
        end
        in_valid = 1'b0;
        check("t5_count", 32'(sink_q.size()), 32'(nbytes / 3));
        for (int p = 0; p < nbytes / 3 && p < sink_q.size(); p++)
            check("t5_pixel", 32'(sink_q[p]), 32'({src[3*p], src[3*p+1], src[3*p+2]}));

        // 256 frames: frame_cnt wraps to 0 on the 256th eof load.
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < BPF; i++) drive_byte(8'($urandom));
            if (f == 254) check("t6_cnt_255", 32'(frame_cnt), 32'd255);
            if (f == 255) check("t6_cnt_wrap", 32'(frame_cnt), 32'd0);
        end
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_pixel_framer.md
# rgb_pixel_framer

Downstream stage of the byte-serial image editor core (`Main`). It accepts the processed `out_byte` stream (R, G, B bytes per pixel, raster order) over a valid/ready handshake. It packs each triple into a 24-bit pixel, tags it with column/row coordinates and frame markers, and holds it in a single-entry output register until the sink (file writer, display or DMA) takes it. Default geometry is 256×128×3 = 98304 bytes per frame.

## Interface
Parameters:
- `IMG_W`, 256, pixels per row (≥2)
- `IMG_H`, 128, rows per frame (≥2)
- `XW`, `$clog2(IMG_W)`, column index width (derived, not overridden)
- `YW`, `$clog2(IMG_H)`, row index width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_byte` holds a valid byte
- `in_byte`  in  8  processed byte from `Main`
- `in_ready`  out  1  byte is accepted this cycle when `in_valid && in_ready`
- `out_valid`  out  1  output register holds a pixel
- `out_ready`  in  1  sink takes the pixel when `out_valid && out_ready`
- `out_rgb`  out  24  {R,G,B}; first byte of the triple in [23:16]
- `out_x`  out  XW  column of the held pixel
- `out_y`  out  YW  row of the held pixel
- `out_sof`  out  1  held pixel is (0,0)
- `out_eol`  out  1  held pixel has x = IMG_W-1
- `out_eof`  out  1  held pixel is (IMG_W-1, IMG_H-1)
- `frame_cnt`  out  8  completed frames; wraps 255→0

## Operation
- Byte phase counter `ph` takes values 0, 1, 2.
  - On an accepted byte, `ph` advances and wraps 2→0.
  - Bytes at ph0 and ph1 go to internal R and G registers.
- ph0 and ph1 bytes are always accepted: `in_ready` = 1 when `ph`≠2.
- At ph2, `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`, with no added register stage.
- An accepted ph2 byte loads the output register and sets `out_valid`:
  - `out_rgb` = {R, G, in_byte}
  - `out_x` / `out_y` = pixel counters `px` / `py`
  - the flags are decoded from `px` / `py`
- Pixel counters advance on each loaded pixel, not on each sink transfer:
  - `px` increments.
  - At IMG_W-1, `px` goes to 0 and `py` increments.
  - At (IMG_W-1, IMG_H-1), both go to 0 and `frame_cnt` increments, in the same cycle the eof pixel loads.
- Sink transfer with no new load clears `out_valid`. Load and transfer in the same cycle keeps `out_valid`=1 with the new contents.
- Output fields are stable while `out_valid && !out_ready`.
- `in_valid`=0 stalls with no state change. No byte is dropped or duplicated.

## Timing
- Reset, effective on the first rising edge with `rst`=1:
  - `ph`, `px`, `py` = 0
  - `out_valid` = 0
  - `out_rgb`, `out_x`, `out_y` = 0
  - all flags = 0
  - `frame_cnt` = 0
- `in_ready` = 0 while `rst`=1, and 1 on the first cycle after release.
- Reset mid-pixel or mid-frame discards the partial triple and any held pixel. The next accepted byte is R of pixel (0,0).
- Latency: `out_valid` rises on the edge that accepts the B byte, so the pixel is visible in the following cycle.
- Throughput: 1 byte/cycle sustained with `out_ready`=1 (one pixel per 3 cycles). Back-to-back frames need no gap.
- Backpressure: with `out_ready`=0, at most 2 further bytes (R, G of the next pixel) are absorbed. `in_ready` then drops at ph2.
- `frame_cnt` updates at the eof load edge, not at eof transfer.

## Test plan
- Reset then 3 bytes 0x11, 0x22, 0x33 with `out_ready`=1:
  - `out_valid`=1 one cycle later
  - `out_rgb`=0x112233, x=0, y=0, `out_sof`=1, `out_eol`=0
  - `out_valid`=0 the following cycle.
- Full frame of 98304 bytes, byte value = index mod 256, `out_ready`=1:
  - 32768 pixels in order
  - pixel 255 has `out_eol`=1, x=255, y=0
  - last pixel has `out_eof`=1, x=255, y=127
  - `frame_cnt` 0→1
  - next frame's first pixel has `out_sof`=1.
- Hold `out_ready`=0 with a held pixel, stream 0xA0, 0xA1, 0xA2:
  - first two bytes are accepted
  - `in_ready`=0 at ph2, and the held pixel does not change
  - `out_ready`=1 for one cycle: 0xA2 is accepted that same cycle, and `out_rgb`=0xA0A1A2 the cycle after.
- Random `in_valid` and `out_ready` at 50% over 2 frames: output pixel sequence equals a reference model of the input triples; no loss or duplication.
- Assert `rst` for 1 cycle after 4 bytes, with ph=1 and one pixel held:
  - `out_valid`=0 and `frame_cnt`=0
  - next triple 0x01, 0x02, 0x03 gives `out_rgb`=0x010203 at (0,0) with `out_sof`=1.
- Run 256 frames: `frame_cnt` wraps 255→0 on the 256th eof load.
